mem_bus_ctrl: RTL

Parametrised data-side memory controller for the mips32 single-cycle system. It replaces the directly wired, zero-latency data memory. It adds configurable wait states with a stall handshake to the core, byte-lane writes, a small memory-mapped I/O region and bus-error detection. It sits between the core's data port and its internal word-addressed RAM.

---
 rtl/mem_bus_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: data-side memory controller for the mips32 single-cycle core.
// Adds programmable wait states with a stall handshake, byte-lane writes to an
// internal word RAM, a small MMIO window (GPIO, CYCLE, ERRCNT) and bus-error
// detection. Optional feature macro: MEM_BUS_ERR_IRQ_EN (sticky err_irq output
// plus a read-only IRQ register at MMIO offset 0xC).
//
// The access is carried out on the clock edge that enters RESP, so rdata,
// rdata_valid and bus_err are registered and visible for the whole RESP cycle.
module mem_bus_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  bus_err,
    output logic [DATA_W-1:0]     gpio_out
`ifdef MEM_BUS_ERR_IRQ_EN
    ,
    output logic                  err_irq
`endif
);

    localparam int          BE_W      = DATA_W / 8;
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [BE_W-1:0]   l_be;
    logic [DATA_W-1:0] cycle_cnt;
    logic [DATA_W-1:0] err_cnt;
    logic              irq_q;

    logic [DATA_W-1:0] ram [DEPTH];

    // Access operands: with zero wait states the access happens on the accept
    // edge itself, so the live request is used while still in IDLE.
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;

    logic              go_resp;
    logic              misalign, in_ram, in_mmio, err;
    logic [15:0]       mmio_off;
    logic [AW-1:0]     ram_idx;
    logic [DATA_W-1:0] rd_val;
    logic              gpio_wr, errcnt_clr, ram_we;

    // Select live request in IDLE, latched request otherwise
    always_comb begin
        acc_we    = l_we;
        acc_addr  = l_addr;
        acc_wdata = l_wdata;
        acc_be    = l_be;
        if (state == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign stall   = ((state == ST_IDLE) && req_valid) || (state == ST_WAIT);
    assign go_resp = ((state == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && (cnt == 4'd0));

    // Address decode, error classification and read-data mux
    always_comb begin
        misalign   = acc_addr[1:0] != 2'b00;
        in_ram     = acc_addr < RAM_BYTES;
        in_mmio    = acc_addr >= MMIO_BASE;
        err        = misalign || (!in_ram && !in_mmio);
        mmio_off   = acc_addr[15:0];
        ram_idx    = acc_addr[AW+1:2];
        gpio_wr    = !err && in_mmio && acc_we && (mmio_off == 16'h0000);
        errcnt_clr = !err && in_mmio && acc_we && (mmio_off == 16'h0008) && (|acc_be);
        ram_we     = go_resp && !reset && !err && in_ram && acc_we;
        rd_val     = '0;
        if (!err) begin
            if (in_ram) begin
                rd_val = ram[ram_idx];
            end else begin
                case (mmio_off)
                    16'h0000: rd_val = gpio_out;
                    16'h0004: rd_val = cycle_cnt;
                    16'h0008: rd_val = err_cnt;
`ifdef MEM_BUS_ERR_IRQ_EN
                    16'h000C: rd_val = {{(DATA_W-1){1'b0}}, irq_q};
`endif
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    // RAM byte-lane writes; contents survive reset, in-flight writes are dropped
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) ram[ram_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
            end
        end
    end

    // Access FSM, response registers and MMIO state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            l_we        <= 1'b0;
            l_addr      <= '0;
            l_wdata     <= '0;
            l_be        <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            gpio_out    <= '0;
            cycle_cnt   <= '0;
            err_cnt     <= '0;
            irq_q       <= 1'b0;
        end else begin
            cycle_cnt   <= cycle_cnt + DATA_W'(1);
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        l_we    <= req_we;
                        l_addr  <= req_addr;
                        l_wdata <= req_wdata;
                        l_be    <= req_be;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase

            if (go_resp) begin
                rdata_valid <= 1'b1;
                bus_err     <= err;
                rdata       <= acc_we ? '0 : rd_val;
                if (gpio_wr) begin
                    for (int i = 0; i < BE_W; i++) begin
                        if (acc_be[i]) gpio_out[i*8 +: 8] <= acc_wdata[i*8 +: 8];
                    end
                end
                if (err) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + DATA_W'(1);
                    irq_q <= 1'b1;
                end else if (errcnt_clr) begin
                    err_cnt <= '0;
                    irq_q   <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_BUS_ERR_IRQ_EN
    assign err_irq = irq_q;
`else
    // Without the IRQ feature the sticky flag never leaves the block.
    logic irq_unused;
    assign irq_unused = irq_q;
`endif

endmodule
